sigma_icp_accumulator: RTL and testbench



---
 rtl/sigma_icp_accumulator.sv | 170 +++++++++++++++++
 tb/tb_sigma_icp_accumulator.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_icp_accumulator.sv
// Per-frame sum of squared ICP residuals and correspondence count, 3-stage pipeline.
// Optional outlier rejection is enabled by defining SIGMA_ACC_OUTLIER_REJECT_EN.
module sigma_icp_accumulator #(
    parameter int unsigned CLOUD_BW  = 8,
    parameter int unsigned H_SIZE_BW = 10,
    parameter int unsigned V_SIZE_BW = 10,
    parameter int unsigned RES_BW    = CLOUD_BW,
    parameter int unsigned ACC_BW    = 4 * CLOUD_BW,
    parameter int unsigned CNT_BW    = H_SIZE_BW + V_SIZE_BW
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_frame_start,
    input  logic                     i_frame_end,
    input  logic                     i_valid,
    input  logic                     i_corresp_valid,
    input  logic signed [RES_BW-1:0] i_residual,
`ifdef SIGMA_ACC_OUTLIER_REJECT_EN
    input  logic        [RES_BW-2:0] i_outlier_thr,
    output logic        [CNT_BW-1:0] o_reject_count,
`endif
    output logic                     o_frame_end,
    output logic        [ACC_BW-1:0] o_sigma_s_icp,
    output logic        [CNT_BW-1:0] o_corresp_count,
    output logic                     o_empty
);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                state_q, state_d;
    logic                  samp_raw;
    logic [2*RES_BW-1:0]   abs_ext, sq_full;

    logic [RES_BW-1:0]     s1_abs_d, s1_abs_q;
    logic                  s1_start_d, s1_start_q, s1_end_d, s1_end_q, s1_samp_d, s1_samp_q;
    logic [ACC_BW-1:0]     s2_sq_d, s2_sq_q;
    logic                  s2_start_d, s2_start_q, s2_end_d, s2_end_q, s2_samp_d, s2_samp_q;

    logic                  active, take;
    logic [ACC_BW:0]       acc_sum;
    logic [ACC_BW-1:0]     acc_base, acc_next, acc_d, acc_q;
    logic [CNT_BW-1:0]     cnt_base, cnt_next, cnt_d, cnt_q;
    logic                  frame_end_d, frame_end_q, empty_d, empty_q;
    logic [ACC_BW-1:0]     sigma_d, sigma_q;
    logic [CNT_BW-1:0]     count_d, count_q;
`ifdef SIGMA_ACC_OUTLIER_REJECT_EN
    logic                  s1_rej_d, s1_rej_q, s2_rej_d, s2_rej_q;
    logic [CNT_BW-1:0]     rej_base, rej_next, rej_d, rej_q, rej_out_d, rej_out_q;
`endif

    // S1/S2: magnitude, then square; frame flags travel alongside
    always_comb begin
        samp_raw   = i_valid & i_corresp_valid;
        s1_abs_d   = i_residual[RES_BW-1] ? $unsigned(-i_residual) : $unsigned(i_residual);
        s1_start_d = i_frame_start;
        s1_end_d   = i_frame_end;
`ifdef SIGMA_ACC_OUTLIER_REJECT_EN
        s1_rej_d   = samp_raw && (s1_abs_d > {1'b0, i_outlier_thr});
        s1_samp_d  = samp_raw && !s1_rej_d;
        s2_rej_d   = s1_rej_q;
`else
        s1_samp_d  = samp_raw;
`endif
        abs_ext    = {{RES_BW{1'b0}}, s1_abs_q};
        sq_full    = abs_ext * abs_ext;
        s2_sq_d    = ACC_BW'(sq_full);
        s2_start_d = s1_start_q;
        s2_end_d   = s1_end_q;
        s2_samp_d  = s1_samp_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (s2_end_q)        state_d = IDLE;
        else if (s2_start_q) state_d = ACCUM;
    end

    // A start restarts from zero; once the count saturates, sum and count both freeze
    always_comb begin
        active   = s2_start_q || (state_q == ACCUM);
        acc_base = s2_start_q ? '0 : acc_q;
        cnt_base = s2_start_q ? '0 : cnt_q;
        take     = active && s2_samp_q && (cnt_base != '1);
        acc_sum  = {1'b0, acc_base} + {1'b0, s2_sq_q};
        acc_next = acc_base;
        cnt_next = cnt_base;
        if (take) begin
            acc_next = acc_sum[ACC_BW] ? '1 : acc_sum[ACC_BW-1:0];
            cnt_next = cnt_base + CNT_BW'(1);
        end
        acc_d       = s2_end_q ? '0 : acc_next;
        cnt_d       = s2_end_q ? '0 : cnt_next;
        frame_end_d = s2_end_q;
        sigma_d     = sigma_q;
        count_d     = count_q;
        empty_d     = empty_q;
        if (s2_end_q) begin
            sigma_d = acc_next;
            count_d = cnt_next;
            empty_d = (cnt_next == '0);
        end
`ifdef SIGMA_ACC_OUTLIER_REJECT_EN
        rej_base  = s2_start_q ? '0 : rej_q;
        rej_next  = rej_base;
        if (active && s2_rej_q && (rej_base != '1)) rej_next = rej_base + CNT_BW'(1);
        rej_d     = s2_end_q ? '0 : rej_next;
        rej_out_d = s2_end_q ? rej_next : rej_out_q;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_abs_q    <= '0;
            s1_start_q  <= 1'b0;
            s1_end_q    <= 1'b0;
            s1_samp_q   <= 1'b0;
            s2_sq_q     <= '0;
            s2_start_q  <= 1'b0;
            s2_end_q    <= 1'b0;
            s2_samp_q   <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            frame_end_q <= 1'b0;
            sigma_q     <= '0;
            count_q     <= '0;
            empty_q     <= 1'b0;
`ifdef SIGMA_ACC_OUTLIER_REJECT_EN
            s1_rej_q    <= 1'b0;
            s2_rej_q    <= 1'b0;
            rej_q       <= '0;
            rej_out_q   <= '0;
`endif
        end else begin
            s1_abs_q    <= s1_abs_d;
            s1_start_q  <= s1_start_d;
            s1_end_q    <= s1_end_d;
            s1_samp_q   <= s1_samp_d;
            s2_sq_q     <= s2_sq_d;
            s2_start_q  <= s2_start_d;
            s2_end_q    <= s2_end_d;
            s2_samp_q   <= s2_samp_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            frame_end_q <= frame_end_d;
            sigma_q     <= sigma_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
`ifdef SIGMA_ACC_OUTLIER_REJECT_EN
            s1_rej_q    <= s1_rej_d;
            s2_rej_q    <= s2_rej_d;
            rej_q       <= rej_d;
            rej_out_q   <= rej_out_d;
`endif
        end
    end

    assign o_frame_end     = frame_end_q;
    assign o_sigma_s_icp   = sigma_q;
    assign o_corresp_count = count_q;
    assign o_empty         = empty_q;
`ifdef SIGMA_ACC_OUTLIER_REJECT_EN
    assign o_reject_count  = rej_out_q;
`endif

endmodule

// File: tb/tb_sigma_icp_accumulator.sv
// Directed bench for sigma_icp_accumulator: a default instance plus a narrow
// ACC_BW=16 / CNT_BW=3 instance sharing the same stimulus for saturation cases.
module tb_sigma_icp_accumulator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              fs, fe, vld, cv;
    logic signed [7:0] res;
    logic              fe_o, emp_o, s_fe_o, s_emp_o;
    logic [31:0]       sig_o;
    logic [19:0]       cnt_o;
    logic [15:0]       s_sig_o;
    logic [2:0]        s_cnt_o;
`ifdef SIGMA_ACC_OUTLIER_REJECT_EN
    logic [6:0]        thr;
    logic [19:0]       rej_o;
    logic [2:0]        s_rej_o;
`endif

    sigma_icp_accumulator #(.CLOUD_BW(8), .H_SIZE_BW(10), .V_SIZE_BW(10)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(fs), .i_frame_end(fe),
        .i_valid(vld), .i_corresp_valid(cv), .i_residual(res),
`ifdef SIGMA_ACC_OUTLIER_REJECT_EN
        .i_outlier_thr(thr), .o_reject_count(rej_o),
`endif
        .o_frame_end(fe_o), .o_sigma_s_icp(sig_o), .o_corresp_count(cnt_o), .o_empty(emp_o));

    sigma_icp_accumulator #(.CLOUD_BW(8), .ACC_BW(16), .CNT_BW(3)) dut_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(fs), .i_frame_end(fe),
        .i_valid(vld), .i_corresp_valid(cv), .i_residual(res),
`ifdef SIGMA_ACC_OUTLIER_REJECT_EN
        .i_outlier_thr(thr), .o_reject_count(s_rej_o),
`endif
        .o_frame_end(s_fe_o), .o_sigma_s_icp(s_sig_o), .o_corresp_count(s_cnt_o), .o_empty(s_emp_o));

    typedef struct {
        logic [63:0] sig;
        logic [63:0] cnt;
        logic [63:0] emp;
        logic [63:0] rej;
        int          c;
    } res_t;

    res_t q[$];
    res_t sq[$];
    int   endq[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    res_t mon_r, mon_s;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fe_o === 1'b1) begin
            mon_r.sig = 64'(sig_o); mon_r.cnt = 64'(cnt_o); mon_r.emp = 64'(emp_o);
            mon_r.rej = '0;
`ifdef SIGMA_ACC_OUTLIER_REJECT_EN
            mon_r.rej = 64'(rej_o);
`endif
            mon_r.c = cyc;
            q.push_back(mon_r);
        end
        if (s_fe_o === 1'b1) begin
            mon_s.sig = 64'(s_sig_o); mon_s.cnt = 64'(s_cnt_o); mon_s.emp = 64'(s_emp_o);
            mon_s.rej = '0;
`ifdef SIGMA_ACC_OUTLIER_REJECT_EN
            mon_s.rej = 64'(s_rej_o);
`endif
            mon_s.c = cyc;
            sq.push_back(mon_s);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic drv(input logic s, input logic e, input logic v, input logic c,
                       input logic signed [7:0] r);
        fs = s; fe = e; vld = v; cv = c; res = r;
        if (e) endq.push_back(cyc);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drv(1'b0, 1'b0, 1'b0, 1'b0, 8'sd0);
    endtask

    // Waits (bounded) for the next result of both instances and checks the default one
    task automatic get_res(input string tag, input logic [63:0] esig, input logic [63:0] ecnt,
                           input logic [63:0] eemp, input logic [63:0] erej, output res_t sr);
        res_t r;
        int   n = 0;
        int   e;
        sr = '{default: '0};
        while (q.size() == 0 && n < 10) begin
            idle(1);
            n++;
        end
        chk({tag, "_pulse"}, 64'(q.size() != 0), 64'd1);
        if (q.size() == 0) return;
        r = q.pop_front();
        e = (endq.size() != 0) ? endq.pop_front() : -100;
        chk({tag, "_lat"}, 64'(r.c - e), 64'd3);
        chk({tag, "_sum"}, r.sig, esig);
        chk({tag, "_cnt"}, r.cnt, ecnt);
        chk({tag, "_empty"}, r.emp, eemp);
`ifdef SIGMA_ACC_OUTLIER_REJECT_EN
        chk({tag, "_rej"}, r.rej, erej);
`else
        if (erej != 64'd0) $display("note: %s reject expectation ignored", tag);
`endif
        chk({tag, "_small_pulse"}, 64'(sq.size()), 64'd1);
        if (sq.size() != 0) sr = sq.pop_front();
    endtask

    res_t sr;

    initial begin
        fs = 0; fe = 0; vld = 0; cv = 0; res = 0;
`ifdef SIGMA_ACC_OUTLIER_REJECT_EN
        thr = 7'd127;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_frame_end", 64'(fe_o), 64'd0);
        chk("rst_sum", 64'(sig_o), 64'd0);
        chk("rst_cnt", 64'(cnt_o), 64'd0);
        chk("rst_empty", 64'(emp_o), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Four samples 3,-4,0,127
        drv(1, 0, 1, 1, 8'sd3);
        drv(0, 0, 1, 1, -8'sd4);
        drv(0, 0, 1, 1, 8'sd0);
        drv(0, 1, 1, 1, 8'sd127);
        get_res("four", 64'd16154, 64'd4, 64'd0, 64'd0, sr);
        idle(3);
        chk("hold_pulse_low", 64'(fe_o), 64'd0);
        chk("hold_sum", 64'(sig_o), 64'd16154);
        chk("hold_cnt", 64'(cnt_o), 64'd4);

        // Most negative residual in a single-pixel frame
        drv(1, 1, 1, 1, -8'sd128);
`ifdef SIGMA_ACC_OUTLIER_REJECT_EN
        get_res("single", 64'd0, 64'd0, 64'd1, 64'd1, sr);
`else
        get_res("single", 64'd16384, 64'd1, 64'd0, 64'd0, sr);
`endif
        idle(2);

        // Valid pixels without correspondence, then frame_end alone while idle
        drv(1, 0, 1, 0, 8'sd50);
        drv(0, 0, 1, 0, -8'sd9);
        drv(0, 1, 1, 0, 8'sd7);
        get_res("nocorr", 64'd0, 64'd0, 64'd1, 64'd0, sr);
        drv(0, 0, 1, 1, 8'sd20);
        drv(0, 1, 1, 1, 8'sd20);
        get_res("endonly", 64'd0, 64'd0, 64'd1, 64'd0, sr);
        idle(2);

        // Restart mid-frame discards the partial sum
        drv(1, 0, 1, 1, 8'sd9);
        drv(0, 0, 1, 1, 8'sd9);
        drv(1, 0, 1, 1, 8'sd2);
        drv(0, 1, 1, 1, -8'sd2);
        get_res("restart", 64'd8, 64'd2, 64'd0, 64'd0, sr);
        idle(2);

        // Reset after 10 samples of a frame
        drv(1, 0, 1, 1, 8'sd1);
        repeat (9) drv(0, 0, 1, 1, 8'sd1);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(6);
        chk("rst_no_pulse", 64'(q.size()), 64'd0);
        chk("rst_mid_sum", 64'(sig_o), 64'd0);
        drv(1, 0, 1, 1, 8'sd1);
        drv(0, 1, 1, 1, 8'sd1);
        get_res("post_rst", 64'd2, 64'd2, 64'd0, 64'd0, sr);
        idle(2);

        // Counter saturation on the narrow instance (max 7)
        drv(1, 0, 1, 1, 8'sd1);
        repeat (7) drv(0, 0, 1, 1, 8'sd1);
        drv(0, 1, 1, 1, 8'sd1);
        get_res("cnt_sat", 64'd9, 64'd9, 64'd0, 64'd0, sr);
        chk("cnt_sat_small_cnt", sr.cnt, 64'd7);
        chk("cnt_sat_small_sum", sr.sig, 64'd7);
        idle(2);

        // Accumulator saturation on the narrow instance (5*16129 > 65535)
        drv(1, 0, 1, 1, 8'sd127);
        repeat (3) drv(0, 0, 1, 1, -8'sd127);
        drv(0, 1, 1, 1, 8'sd127);
        get_res("acc_sat", 64'd80645, 64'd5, 64'd0, 64'd0, sr);
        chk("acc_sat_small_sum", sr.sig, 64'd65535);
        chk("acc_sat_small_cnt", sr.cnt, 64'd5);
        idle(2);

        // Back-to-back frames with no bubble
        drv(1, 0, 1, 1, 8'sd2);
        drv(0, 1, 1, 1, 8'sd3);
        drv(1, 1, 1, 1, 8'sd5);
        drv(1, 0, 1, 1, 8'sd1);
        drv(0, 1, 1, 1, -8'sd1);
        get_res("b2b_a", 64'd13, 64'd2, 64'd0, 64'd0, sr);
        get_res("b2b_b", 64'd25, 64'd1, 64'd0, 64'd0, sr);
        get_res("b2b_c", 64'd2, 64'd2, 64'd0, 64'd0, sr);
        idle(2);

`ifdef SIGMA_ACC_OUTLIER_REJECT_EN
        thr = 7'd10;
        drv(1, 0, 1, 1, 8'sd5);
        drv(0, 0, 1, 1, -8'sd11);
        drv(0, 1, 1, 1, 8'sd10);
        get_res("outlier", 64'd125, 64'd2, 64'd0, 64'd1, sr);
        idle(2);
`endif

        chk("no_extra_pulse", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
